// File: rtl/knights_pkg.sv
// rtl/knights_pkg.sv - shared response codes, arbiter state and source types
package knights_pkg;

    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_MOVE = 8'h5A;
    localparam logic [7:0] RESP_TMO  = 8'hEE;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} arb_state_t;
    typedef enum logic {SRC_UART, SRC_TOUR} src_t;

    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin picker with a UART-side request mask
module rr_pick2
    import knights_pkg::*;
(
    input  logic uart_req_i,
    input  logic tour_req_i,
    input  logic mask_i,
    input  logic last_owner_i,
    output logic valid_o,
    output logic winner_o
);

    logic uart_cand;

    always_comb begin
        uart_cand = uart_req_i & ~mask_i;
        valid_o   = uart_cand | tour_req_i;
        // On a tie the source that did not own the port last time wins.
        if (uart_cand && tour_req_i) begin
            winner_o = (last_owner_i == SRC_UART) ? SRC_TOUR : SRC_UART;
        end else begin
            winner_o = tour_req_i;
        end
    end

endmodule

// File: rtl/cmd_arbiter.sv
// rtl/cmd_arbiter.sv - shares the cmd_proc port between UART and tour sources
module cmd_arbiter
    import knights_pkg::*;
#(
    parameter logic [23:0] DONE_TMO = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] uart_cmd,
    input  logic        uart_rdy,
    output logic        uart_clr,
    input  logic [15:0] tour_cmd,
    input  logic        tour_rdy,
    input  logic        tour_last,
    input  logic        tour_lock,
    output logic        tour_clr,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [7:0]  resp,
    output logic        resp_trmt,
    output logic [5:0]  tour_cnt,
    output logic        tmo_err
);

    arb_state_t  state_q, state_d;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        uart_clr_q, uart_clr_d;
    logic        tour_clr_q, tour_clr_d;
    src_t        owner_q, owner_d;
    logic        owner_last_q, owner_last_d;
    src_t        last_owner_q, last_owner_d;
    logic [7:0]  resp_q, resp_d;
    logic        resp_trmt_q, resp_trmt_d;
    logic [5:0]  tour_cnt_q, tour_cnt_d;
    logic        tmo_err_q, tmo_err_d;
    logic [23:0] wd_q, wd_d;
    logic        lock_q;

    logic        pick_valid;
    logic        pick_winner;
    logic        lock_rise;
    logic        wd_hit;

    rr_pick2 u_pick (
        .uart_req_i   (uart_rdy),
        .tour_req_i   (tour_rdy),
        .mask_i       (tour_lock),
        .last_owner_i (last_owner_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    assign lock_rise = tour_lock & ~lock_q;
    assign wd_hit    = (wd_q == DONE_TMO - 24'd1);

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cmd_rdy_d    = cmd_rdy_q;
        uart_clr_d   = 1'b0;
        tour_clr_d   = 1'b0;
        owner_d      = owner_q;
        owner_last_d = owner_last_q;
        last_owner_d = last_owner_q;
        resp_d       = resp_q;
        resp_trmt_d  = 1'b0;
        tour_cnt_d   = tour_cnt_q;
        tmo_err_d    = tmo_err_q;
        wd_d         = wd_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    owner_d   = src_t'(pick_winner);
                    cmd_rdy_d = 1'b1;
                    wd_d      = 24'd0;
                    state_d   = ISSUE;
                    if (src_t'(pick_winner) == SRC_TOUR) begin
                        cmd_d        = tour_cmd;
                        owner_last_d = tour_last;
                        tour_clr_d   = 1'b1;
                    end else begin
                        cmd_d        = uart_cmd;
                        owner_last_d = 1'b0;
                        uart_clr_d   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                wd_d = wd_q + 24'd1;
                // A stalled consumer is abandoned even if it never took the command.
                if (wd_hit) begin
                    cmd_rdy_d   = 1'b0;
                    resp_d      = RESP_TMO;
                    tmo_err_d   = 1'b1;
                    resp_trmt_d = 1'b1;
                    state_d     = RESP;
                end else if (clr_cmd_rdy) begin
                    cmd_rdy_d = 1'b0;
                    state_d   = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                wd_d = wd_q + 24'd1;
                if (send_resp) begin
                    resp_d      = (owner_q == SRC_UART || owner_last_q) ? RESP_DONE : RESP_MOVE;
                    resp_trmt_d = 1'b1;
                    state_d     = RESP;
                    if (owner_q == SRC_TOUR) begin
                        tour_cnt_d = sat_inc6(tour_cnt_q);
                    end
                end else if (wd_hit) begin
                    resp_d      = RESP_TMO;
                    tmo_err_d   = 1'b1;
                    resp_trmt_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new tour starts with a clean count and error flag.
        if (lock_rise) begin
            tour_cnt_d = 6'd0;
            tmo_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= 16'd0;
            cmd_rdy_q    <= 1'b0;
            uart_clr_q   <= 1'b0;
            tour_clr_q   <= 1'b0;
            owner_q      <= SRC_UART;
            owner_last_q <= 1'b0;
            last_owner_q <= SRC_UART;
            resp_q       <= 8'd0;
            resp_trmt_q  <= 1'b0;
            tour_cnt_q   <= 6'd0;
            tmo_err_q    <= 1'b0;
            wd_q         <= 24'd0;
            lock_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            cmd_rdy_q    <= cmd_rdy_d;
            uart_clr_q   <= uart_clr_d;
            tour_clr_q   <= tour_clr_d;
            owner_q      <= owner_d;
            owner_last_q <= owner_last_d;
            last_owner_q <= last_owner_d;
            resp_q       <= resp_d;
            resp_trmt_q  <= resp_trmt_d;
            tour_cnt_q   <= tour_cnt_d;
            tmo_err_q    <= tmo_err_d;
            wd_q         <= wd_d;
            lock_q       <= tour_lock;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign uart_clr  = uart_clr_q;
    assign tour_clr  = tour_clr_q;
    assign resp      = resp_q;
    assign resp_trmt = resp_trmt_q;
    assign tour_cnt  = tour_cnt_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// tb/tb_cmd_arbiter.sv - randomized self-checking bench for cmd_arbiter
module tb_cmd_arbiter;

    localparam int TMO = 100;

    logic        clk;
    logic        rst;
    logic [15:0] uart_cmd;
    logic        uart_rdy;
    logic        uart_clr;
    logic [15:0] tour_cmd;
    logic        tour_rdy;
    logic        tour_last;
    logic        tour_lock;
    logic        tour_clr;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        resp_trmt;
    logic [5:0]  tour_cnt;
    logic        tmo_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: who owned the port last, and tour completions so far.
    bit m_last_tour;
    int m_cnt;

    cmd_arbiter #(.DONE_TMO(24'(TMO))) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_cmd    (uart_cmd),
        .uart_rdy    (uart_rdy),
        .uart_clr    (uart_clr),
        .tour_cmd    (tour_cmd),
        .tour_rdy    (tour_rdy),
        .tour_last   (tour_last),
        .tour_lock   (tour_lock),
        .tour_clr    (tour_clr),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .resp_trmt   (resp_trmt),
        .tour_cnt    (tour_cnt),
        .tmo_err     (tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic grant_only(input bit wu, input bit wt, input logic [15:0] uc,
                              input logic [15:0] tc, input bit lst, output bit w_tour);
        bit cu;
        uart_cmd  = uc;
        tour_cmd  = tc;
        uart_rdy  = wu;
        tour_rdy  = wt;
        tour_last = lst;
        cu = wu && !tour_lock;
        if (cu && wt) w_tour = !m_last_tour;
        else          w_tour = wt;
        @(negedge clk);
        chk("grant_tour_clr", 32'(tour_clr), 32'(w_tour));
        chk("grant_uart_clr", 32'(uart_clr), 32'(!w_tour));
        chk("grant_cmd", 32'(cmd), 32'(w_tour ? tc : uc));
        chk("grant_cmd_rdy", 32'(cmd_rdy), 32'd1);
        if (w_tour) begin
            tour_rdy  = 1'b0;
            tour_last = 1'b0;
        end else begin
            uart_rdy = 1'b0;
        end
    endtask

    task automatic complete(input bit w_tour, input bit lst);
        int cd;
        int rd;
        logic [7:0] er;
        cd = $urandom_range(0, 4);
        rd = $urandom_range(0, 4);
        repeat (cd) begin
            send_resp = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("issue_hold_rdy", 32'(cmd_rdy), 32'd1);
        clr_cmd_rdy = 1'b1;
        send_resp   = 1'($urandom_range(0, 1));
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        chk("clr_drops_rdy", 32'(cmd_rdy), 32'd0);
        chk("early_resp_ignored", 32'(resp_trmt), 32'd0);
        repeat (rd) @(negedge clk);
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        er = (!w_tour || lst) ? 8'hA5 : 8'h5A;
        if (w_tour && m_cnt < 63) m_cnt++;
        chk("resp_trmt_hi", 32'(resp_trmt), 32'd1);
        chk("resp_val", 32'(resp), 32'(er));
        chk("tour_cnt", 32'(tour_cnt), 32'(m_cnt));
        @(negedge clk);
        chk("resp_trmt_lo", 32'(resp_trmt), 32'd0);
        m_last_tour = w_tour;
    endtask

    task automatic do_txn(input bit wu, input bit wt, input logic [15:0] uc,
                          input logic [15:0] tc, input bit lst);
        bit w;
        grant_only(wu, wt, uc, tc, lst, w);
        complete(w, lst);
    endtask

    initial begin
        bit w;
        bit wu;
        bit wt;
        int bad;
        int elapsed;

        rst = 1'b1;
        uart_cmd = 16'd0; uart_rdy = 1'b0; tour_cmd = 16'd0; tour_rdy = 1'b0;
        tour_last = 1'b0; tour_lock = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
        m_last_tour = 1'b0;
        m_cnt = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd", 32'(cmd), 32'd0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("rst_resp", 32'(resp), 32'd0);
        chk("rst_resp_trmt", 32'(resp_trmt), 32'd0);
        chk("rst_tour_cnt", 32'(tour_cnt), 32'd0);
        chk("rst_tmo_err", 32'(tmo_err), 32'd0);
        chk("rst_clrs", 32'({uart_clr, tour_clr}), 32'd0);
        rst = 1'b0;

        // Reset tie: tour is granted first.
        do_txn(1'b1, 1'b1, 16'($urandom), 16'h4002, 1'b0);

        // Round-robin under continuous contention.
        repeat (6) do_txn(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        // Random request mix.
        repeat (20) begin
            wu = 1'($urandom_range(0, 1));
            wt = wu ? 1'($urandom_range(0, 1)) : 1'b1;
            do_txn(wu, wt, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Lock masks a lone UART request.
        tour_lock = 1'b1;
        uart_rdy  = 1'b1;
        tour_rdy  = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (uart_clr || tour_clr || cmd_rdy) bad++;
        end
        chk("lock_no_grant", 32'(bad), 32'd0);
        m_cnt = 0;
        chk("lock_cnt_clear", 32'(tour_cnt), 32'(m_cnt));
        tour_lock = 1'b0;
        do_txn(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0);

        // Full 48-move tour with a pending UART request masked throughout.
        tour_lock = 1'b1;
        @(negedge clk);
        m_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            do_txn(1'b1, 1'b1, 16'($urandom), 16'($urandom), i == 47);
        end
        chk("tour_cnt_48", 32'(tour_cnt), 32'd48);
        uart_rdy  = 1'b0;
        tour_lock = 1'b0;
        @(negedge clk);

        // Watchdog abort while waiting for completion.
        grant_only(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, w);
        elapsed = 0;
        while (elapsed < 3 * TMO && !resp_trmt) begin
            clr_cmd_rdy = (elapsed == 3);
            @(negedge clk);
            elapsed++;
        end
        clr_cmd_rdy = 1'b0;
        chk("wd_wait_cycles", 32'(elapsed), 32'(TMO));
        chk("wd_resp", 32'(resp), 32'hEE);
        chk("wd_tmo_err", 32'(tmo_err), 32'd1);
        chk("wd_cmd_rdy", 32'(cmd_rdy), 32'd0);
        @(negedge clk);
        chk("wd_trmt_lo", 32'(resp_trmt), 32'd0);
        m_last_tour = w;

        // Watchdog abort while the command is never consumed.
        grant_only(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b0, w);
        elapsed = 0;
        while (elapsed < 3 * TMO && !resp_trmt) begin
            @(negedge clk);
            elapsed++;
        end
        chk("wd_issue_cycles", 32'(elapsed), 32'(TMO));
        chk("wd_issue_resp", 32'(resp), 32'hEE);
        chk("wd_issue_rdy_drop", 32'(cmd_rdy), 32'd0);
        chk("wd_issue_cnt", 32'(tour_cnt), 32'(m_cnt));
        @(negedge clk);
        m_last_tour = w;

        // Rising tour_lock clears the error and the count.
        tour_lock = 1'b1;
        @(negedge clk);
        m_cnt = 0;
        chk("lock_rise_tmo_clr", 32'(tmo_err), 32'd0);
        chk("lock_rise_cnt_clr", 32'(tour_cnt), 32'(m_cnt));
        tour_lock = 1'b0;
        @(negedge clk);

        // Reset in the middle of a command.
        grant_only(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, w);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_cmd", 32'(cmd), 32'd0);
        chk("midrst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        chk("midrst_resp", 32'(resp), 32'd0);
        chk("midrst_trmt", 32'(resp_trmt), 32'd0);
        chk("midrst_clrs", 32'({uart_clr, tour_clr}), 32'd0);
        send_resp = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            send_resp = 1'b0;
            if (resp_trmt) bad++;
        end
        chk("midrst_no_resp", 32'(bad), 32'd0);
        m_last_tour = 1'b0;
        m_cnt = 0;
        do_txn(1'b1, 1'b1, 16'($urandom), 16'($urandom), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_arbiter.md
# cmd_arbiter

Sequences the single `cmd_proc` command port between the two command sources in `KnightsTour`: the UART command path (`UART_wrapper`) and the tour move sequencer (`TourCmd`). The block accepts one 16-bit command at a time, holds it until `cmd_proc` reports completion, and routes the resulting response byte to the UART transmitter. It also counts completed tour commands and recovers from a stalled `cmd_proc` with a watchdog.

## Interface
- `DONE_TMO`, default 24'd10_000_000: cycles to wait for `send_resp` before abort.
- `clk` input 1: system clock, all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `uart_cmd` input 16: command from the UART path.
- `uart_rdy` input 1: `uart_cmd` valid, held until cleared.
- `uart_clr` output 1: one-cycle pulse; `uart_cmd` captured.
- `tour_cmd` input 16: command from `TourCmd`.
- `tour_rdy` input 1: `tour_cmd` valid, held until cleared.
- `tour_last` input 1: qualifies `tour_cmd` as the final command of the tour.
- `tour_lock` input 1: tour in progress; UART requests are not granted while high.
- `cmd` output 16: registered command to `cmd_proc`.
- `cmd_rdy` output 1: `cmd` valid; held until `clr_cmd_rdy`.
- `clr_cmd_rdy` input 1: `cmd_proc` consumed `cmd`.
- `send_resp` input 1: `cmd_proc` finished the granted command.
- `resp` output 8: response byte.
- `resp_trmt` output 1: one-cycle pulse; `resp` valid.
- `tour_cnt` output 6: completed tour commands since the last tour start.
- `tmo_err` output 1: sticky; set on watchdog abort.

## Operation
- **States:** IDLE, ISSUE, WAIT_DONE, RESP.
- **IDLE arbitration:**
  - Candidates are `tour_rdy`, and `uart_rdy` only when `tour_lock` is 0.
  - A single candidate wins.
  - On a tie, the source opposite `last_owner` wins (round-robin).
- **Grant:** latch the winner's command into `cmd`, record `owner` and `owner_last` (`tour_last` when owner is tour, else 0), pulse that source's clr, go to ISSUE.
- **ISSUE:**
  - `cmd_rdy` is 1.
  - On `clr_cmd_rdy`: `cmd_rdy` becomes 0 and the state goes to WAIT_DONE.
  - The watchdog counter clears on grant.
- **WAIT_DONE, on `send_resp`:**
  - Response is 0xA5 if owner is UART or `owner_last` is 1; otherwise 0x5A.
  - If owner is tour, `tour_cnt` increments, saturating at 63.
  - Next state is RESP.
- **WAIT_DONE, on watchdog:** when the watchdog reaches `DONE_TMO-1`, `resp`=0xEE, `tmo_err`=1, next state is RESP.
- **RESP:** `resp_trmt` pulses for 1 cycle, `last_owner`=owner, then IDLE.
- **Watchdog scope:** runs in both ISSUE and WAIT_DONE. A timeout in ISSUE also drops `cmd_rdy`.
- **Counter and error clear:** `tour_cnt` clears on a rising edge of `tour_lock`. `tmo_err` clears on a rising edge of `tour_lock` or on `rst`.
- **Off-state inputs:** `send_resp` or `clr_cmd_rdy` outside their states are ignored.
- **`tour_lock` mid-grant:** a grant already made proceeds normally.

## Timing
- **Reset values:** all outputs 0, state IDLE, `last_owner`=UART, so a reset tie grants the tour first.
- **Request to issue:** `rdy` sampled high in IDLE gives the clr pulse and `cmd`/`cmd_rdy` valid on the next edge (1-cycle latency).
- **Clr timing:** the source's `rdy` must fall by the cycle after clr. The arbiter does not re-sample in that cycle because it is no longer in IDLE.
- **Completion to response:** `send_resp` in cycle N gives `resp_trmt` high in cycle N+1 and IDLE in N+2.
- **Throughput:** the next grant is possible in N+2.
- **Simultaneous `clr_cmd_rdy` and `send_resp` in ISSUE:** `clr` is taken. `send_resp` is dropped, so `cmd_proc` must not finish in the same cycle it clears.
- **Reset mid-operation:** state returns to IDLE next edge, the in-flight command is discarded, and no clr or response is emitted.

## Structure
- **Shared package `knights_pkg`:**
  - Constants `RESP_DONE`=8'hA5, `RESP_MOVE`=8'h5A, `RESP_TMO`=8'hEE.
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} arb_state_t`.
  - `typedef enum logic {SRC_UART, SRC_TOUR} src_t`.
- **Sub-module `rr_pick2`:** a 2-way round-robin picker with mask (`tour_lock`) and `last_owner` input, instantiated once.
- **Instantiation:** `cmd_arbiter` sits between `UART_wrapper`/`TourCmd` and `cmd_proc` in `KnightsTour`.

## Test plan
- **Reset tie:** after `rst`, `uart_rdy`=`tour_rdy`=1 in the same cycle with `tour_cmd`=16'h4002.
  - Expect `tour_clr` pulse, `cmd`=16'h4002 and `cmd_rdy` one cycle later, `uart_clr` stays 0.
  - On `send_resp`: `resp`=0x5A with a 1-cycle `resp_trmt`, `tour_cnt`=1.
- **Round-robin:** both requests held continuously with `clr_cmd_rdy`/`send_resp` returned.
  - Grants alternate tour, UART, tour.
  - UART responses are 0xA5.
- **Lock:** `tour_lock`=1 with `uart_rdy`=1 alone.
  - No grant for 1000 cycles.
  - Dropping `tour_lock` grants UART within 1 cycle.
- **Full tour:** 48 tour commands under `tour_lock`, the last with `tour_last`=1.
  - 47 responses 0x5A, the final response 0xA5, `tour_cnt`=48.
- **Watchdog:** `DONE_TMO`=100, grant issued, `clr_cmd_rdy` given, `send_resp` never asserted.
  - After 100 cycles: `resp`=0xEE, `tmo_err`=1, state IDLE.
- **Mid-operation reset:** `rst` during WAIT_DONE.
  - Next cycle: all outputs 0.
  - A later `send_resp` produces no `resp_trmt`.
